// File: rtl/err_event_monitor_if.sv
// err_event_monitor_if: event inputs, clears, readback select and counter/flag outputs of the monitor
interface err_event_monitor_if #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 5
);
    logic [N_CH-1:0]       I_EV;
    logic [N_CH-1:0]       I_CLR;
    logic [SEL_W-1:0]      I_SEL;
    logic [N_CH*CNT_W-1:0] O_CNT;
    logic [CNT_W-1:0]      O_SEL_CNT;
    logic [N_CH-1:0]       O_ALARM;
    logic                  O_ANY_ALARM;
    logic [N_CH-1:0]       O_OVF;

    modport master (
        output I_EV, I_CLR, I_SEL,
        input  O_CNT, O_SEL_CNT, O_ALARM, O_ANY_ALARM, O_OVF
    );

    modport slave (
        input  I_EV, I_CLR, I_SEL,
        output O_CNT, O_SEL_CNT, O_ALARM, O_ANY_ALARM, O_OVF
    );
endinterface

// File: rtl/err_event_monitor.sv
// err_event_monitor: N-channel synchronised rising-edge counters with sticky alarm/overflow flags
module err_event_monitor #(
    parameter int N_CH        = 4,
    parameter int SEL_W       = 2,
    parameter int CNT_W       = 5,
    parameter int SAT         = 1,
    parameter int THR         = 16,
    parameter int SYNC_STAGES = 1
) (
    input logic CLK,
    input logic RST_n,
    err_event_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [N_CH-1:0]  sync_d [SYNC_STAGES];
    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  prev_d, prev_q;
    logic [N_CH-1:0]  ev_edge;
    logic [N_CH-1:0]  alarm_d, alarm_q;
    logic [N_CH-1:0]  ovf_d, ovf_q;
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];

    // synchroniser shift, edge detect and per-channel counter/flag update (clear wins over an edge)
    always_comb begin
        sync_d[0] = bus.I_EV;
        for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
        prev_d  = sync_q[SYNC_STAGES-1];
        ev_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
        cnt_d   = cnt_q;
        alarm_d = alarm_q;
        ovf_d   = ovf_q;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.I_CLR[i]) begin
                cnt_d[i]   = '0;
                alarm_d[i] = 1'b0;
                ovf_d[i]   = 1'b0;
            end else if (ev_edge[i]) begin
                cnt_d[i]   = (cnt_q[i] != MAX) ? cnt_q[i] + 1'b1 : ((SAT != 0) ? MAX : '0);
                ovf_d[i]   = ovf_q[i] | (cnt_q[i] == MAX);
                alarm_d[i] = alarm_q[i] | ((THR != 0) && (32'(cnt_d[i]) >= THR));
            end
        end
    end

    // state registers; reset clears everything immediately
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync_q  <= '{default: '0};
            prev_q  <= '0;
            cnt_q   <= '{default: '0};
            alarm_q <= '0;
            ovf_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            ovf_q   <= ovf_d;
        end
    end

    // packed counter bus, combinational readback mux (0 for unused selects) and flag outputs
    always_comb begin
        bus.O_SEL_CNT = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.O_CNT[i*CNT_W +: CNT_W] = cnt_q[i];
            if (32'(bus.I_SEL) == i) bus.O_SEL_CNT = cnt_q[i];
        end
        bus.O_ALARM     = alarm_q;
        bus.O_OVF       = ovf_q;
        bus.O_ANY_ALARM = |alarm_q;
    end
endmodule

// File: tb/tb_err_event_monitor.sv
// tb_err_event_monitor: directed checks of a saturating and a wrapping monitor driven in parallel
module tb_err_event_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ev = '0;
    logic [3:0] clr = '0;
    logic [1:0] sel_s = '0;
    logic [2:0] sel_w = '0;
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    err_event_monitor_if #(.N_CH(4), .SEL_W(2), .CNT_W(5)) s_if ();
    err_event_monitor_if #(.N_CH(4), .SEL_W(3), .CNT_W(5)) w_if ();

    assign s_if.I_EV  = ev;
    assign s_if.I_CLR = clr;
    assign s_if.I_SEL = sel_s;
    assign w_if.I_EV  = ev;
    assign w_if.I_CLR = clr;
    assign w_if.I_SEL = sel_w;

    err_event_monitor #(.N_CH(4), .SEL_W(2), .CNT_W(5), .SAT(1), .THR(16), .SYNC_STAGES(1)) dut (
        .CLK(clk), .RST_n(rst_n), .bus(s_if)
    );

    err_event_monitor #(.N_CH(4), .SEL_W(3), .CNT_W(5), .SAT(0), .THR(16), .SYNC_STAGES(1)) dut_w (
        .CLK(clk), .RST_n(rst_n), .bus(w_if)
    );

    function automatic logic [4:0] ch(input logic [19:0] v, input int i);
        return v[i*5 +: 5];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] m);
        @(negedge clk) ev = m;
        @(negedge clk) ev = '0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cnt", 32'(s_if.O_CNT), 0);
        check("rst_alarm", 32'(s_if.O_ALARM), 0);
        check("rst_ovf", 32'(s_if.O_OVF), 0);
        check("rst_any", 32'(s_if.O_ANY_ALARM), 0);
        check("rst_cnt_w", 32'(w_if.O_CNT), 0);
        @(negedge clk) rst_n = 1'b1;

        @(negedge clk) ev = 4'b0001;
        @(negedge clk);
        check("lat_before", 32'(ch(s_if.O_CNT, 0)), 0);
        ev = '0;
        @(negedge clk);
        check("lat_after", 32'(ch(s_if.O_CNT, 0)), 1);
        @(negedge clk);
        repeat (2) pulse(4'b0001);
        check("ch0_three", 32'(ch(s_if.O_CNT, 0)), 3);
        check("others_zero", 32'(s_if.O_CNT[19:5]), 0);
        check("no_alarm", 32'(s_if.O_ALARM), 0);
        check("no_ovf", 32'(s_if.O_OVF), 0);

        repeat (15) pulse(4'b0010);
        check("sat_15", 32'(ch(s_if.O_CNT, 1)), 15);
        check("sat_alarm_15", 32'(s_if.O_ALARM[1]), 0);
        pulse(4'b0010);
        check("sat_16", 32'(ch(s_if.O_CNT, 1)), 16);
        check("sat_alarm_16", 32'(s_if.O_ALARM[1]), 1);
        check("sat_any_16", 32'(s_if.O_ANY_ALARM), 1);
        repeat (15) pulse(4'b0010);
        check("sat_31", 32'(ch(s_if.O_CNT, 1)), 31);
        check("sat_ovf_31", 32'(s_if.O_OVF[1]), 0);
        pulse(4'b0010);
        check("sat_32", 32'(ch(s_if.O_CNT, 1)), 31);
        check("sat_ovf_32", 32'(s_if.O_OVF[1]), 1);
        check("wrap1_32", 32'(ch(w_if.O_CNT, 1)), 0);
        check("wrap1_ovf", 32'(w_if.O_OVF[1]), 1);
        check("wrap1_alarm", 32'(w_if.O_ALARM[1]), 1);
        repeat (3) pulse(4'b0010);
        check("sat_35", 32'(ch(s_if.O_CNT, 1)), 31);
        check("sat_alarm_35", 32'(s_if.O_ALARM[1]), 1);
        check("wrap1_35", 32'(ch(w_if.O_CNT, 1)), 3);

        repeat (33) pulse(4'b0100);
        check("wrap2_cnt", 32'(ch(w_if.O_CNT, 2)), 1);
        check("wrap2_ovf", 32'(w_if.O_OVF[2]), 1);
        check("wrap2_alarm", 32'(w_if.O_ALARM[2]), 1);
        check("sat2_cnt", 32'(ch(s_if.O_CNT, 2)), 31);
        check("sat2_ovf", 32'(s_if.O_OVF[2]), 1);

        repeat (4) pulse(4'b0001);
        check("ch0_seven", 32'(ch(s_if.O_CNT, 0)), 7);
        @(negedge clk) ev = 4'b0011;
        @(negedge clk) begin ev = '0; clr = 4'b0001; end
        @(negedge clk) clr = '0;
        check("coll_cnt0", 32'(ch(s_if.O_CNT, 0)), 0);
        check("coll_alarm0", 32'(s_if.O_ALARM[0]), 0);
        check("coll_ovf0", 32'(s_if.O_OVF[0]), 0);
        check("coll_w_cnt1", 32'(ch(w_if.O_CNT, 1)), 4);
        check("coll_s_cnt1", 32'(ch(s_if.O_CNT, 1)), 31);

        @(negedge clk) clr = 4'b0010;
        @(negedge clk) clr = '0;
        check("clr1_cnt", 32'(ch(s_if.O_CNT, 1)), 0);
        check("clr1_alarm", 32'(s_if.O_ALARM[1]), 0);
        check("clr1_ovf", 32'(s_if.O_OVF[1]), 0);
        check("clr1_any", 32'(s_if.O_ANY_ALARM), 1);
        check("clr1_w_cnt", 32'(ch(w_if.O_CNT, 1)), 0);

        repeat (3) pulse(4'b0011);
        repeat (6) pulse(4'b0010);
        sel_s = 2'd1; sel_w = 3'd1;
        #1;
        check("sel_s1", 32'(s_if.O_SEL_CNT), 9);
        check("sel_w1", 32'(w_if.O_SEL_CNT), 9);
        sel_s = 2'd0;
        #1;
        check("sel_s0", 32'(s_if.O_SEL_CNT), 3);
        sel_w = 3'd4;
        #1;
        check("sel_w4", 32'(w_if.O_SEL_CNT), 0);
        sel_w = 3'd2;
        #1;
        check("sel_w2", 32'(w_if.O_SEL_CNT), 1);
        sel_w = 3'd7;
        #1;
        check("sel_w7", 32'(w_if.O_SEL_CNT), 0);
        check("alarm1_9", 32'(s_if.O_ALARM[1]), 0);

        @(negedge clk) ev = 4'b1000;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(s_if.O_CNT), 0);
        check("mid_rst_alarm", 32'(s_if.O_ALARM), 0);
        check("mid_rst_ovf", 32'(s_if.O_OVF), 0);
        check("mid_rst_any", 32'(s_if.O_ANY_ALARM), 0);
        check("mid_rst_w_cnt", 32'(w_if.O_CNT), 0);
        check("mid_rst_w_ovf", 32'(w_if.O_OVF), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("level_cnt3", 32'(ch(s_if.O_CNT, 3)), 1);
        check("level_w_cnt3", 32'(ch(w_if.O_CNT, 3)), 1);
        repeat (10) @(negedge clk);
        check("level_hold3", 32'(ch(s_if.O_CNT, 3)), 1);
        ev = '0;
        @(negedge clk);
        pulse(4'b1000);
        check("level_next3", 32'(ch(s_if.O_CNT, 3)), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
